vreg_xbar_arb: RTL

Parametrised NUM_PORT x NUM_BANK crossbar between vector-lane request ports and vector register banks. It replaces the fixed single-cycle crossbar.
- Per-bank round-robin arbitration with burst locking: a granted port owns a bank for its whole burst.
- Read data returns to the requesting port on a registered response path, tagged with its source bank.
- Sits between the lane request logic and the vector register file banks.

---
 rtl/vreg_xbar_arb_if.sv | 42 ++++
 rtl/vreg_xbar_arb.sv | 131 +++++++++++++
 2 files changed

// File: rtl/vreg_xbar_arb_if.sv
// Lane-side request/response and bank-side signals of the vector register crossbar.
// master = lanes plus register banks, slave = the crossbar itself.
interface vreg_xbar_arb_if #(
  parameter int NUM_PORT = 4,
  parameter int NUM_BANK = 8,
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 64,
  parameter int LEN_W    = 7
);
  localparam int BANK_W = $clog2(NUM_BANK);

  logic              req_vld    [NUM_PORT];
  logic [BANK_W-1:0] req_bank   [NUM_PORT];
  logic [ADDR_W-1:0] req_addr   [NUM_PORT];
  logic              req_we     [NUM_PORT];
  logic [DATA_W-1:0] req_wdata  [NUM_PORT];
  logic [LEN_W-1:0]  req_len    [NUM_PORT];
  logic              req_rdy    [NUM_PORT];

  logic              bank_en    [NUM_BANK];
  logic              bank_we    [NUM_BANK];
  logic [ADDR_W-1:0] bank_addr  [NUM_BANK];
  logic [DATA_W-1:0] bank_wdata [NUM_BANK];
  logic [DATA_W-1:0] bank_rdata [NUM_BANK];

  logic              rsp_vld    [NUM_PORT];
  logic              rsp_we     [NUM_PORT];
  logic [BANK_W-1:0] rsp_bank   [NUM_PORT];
  logic [DATA_W-1:0] rsp_rdata  [NUM_PORT];

  modport master (
    output req_vld, req_bank, req_addr, req_we, req_wdata, req_len, bank_rdata,
    input  req_rdy, bank_en, bank_we, bank_addr, bank_wdata,
           rsp_vld, rsp_we, rsp_bank, rsp_rdata
  );

  modport slave (
    input  req_vld, req_bank, req_addr, req_we, req_wdata, req_len, bank_rdata,
    output req_rdy, bank_en, bank_we, bank_addr, bank_wdata,
           rsp_vld, rsp_we, rsp_bank, rsp_rdata
  );
endinterface

// File: rtl/vreg_xbar_arb.sv
// NUM_PORT x NUM_BANK crossbar: per-bank round-robin arbitration with burst locking,
// and a one-cycle registered response path tagged with the serving bank.
module vreg_xbar_arb #(
  parameter int NUM_PORT = 4,
  parameter int NUM_BANK = 8,
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 64,
  parameter int LEN_W    = 7
) (
  input logic            clk,
  input logic            reset,
  vreg_xbar_arb_if.slave bus
);
  localparam int BANK_W = $clog2(NUM_BANK);
  localparam int PORT_W = $clog2(NUM_PORT);

  typedef enum logic {IDLE, LOCKED} bankState_e;

  bankState_e        state_q     [NUM_BANK];
  logic [PORT_W-1:0] owner_q     [NUM_BANK];
  logic [LEN_W-1:0]  remaining_q [NUM_BANK];
  logic [PORT_W-1:0] rrPtr_q     [NUM_BANK];

  logic              grant       [NUM_BANK];
  logic [PORT_W-1:0] winner      [NUM_BANK];
  logic [PORT_W-1:0] candPort;
  logic              portRdy     [NUM_PORT];

  logic              pendVld_q   [NUM_PORT];
  logic              pendVld_d   [NUM_PORT];
  logic              pendWe_q    [NUM_PORT];
  logic              pendWe_d    [NUM_PORT];
  logic [BANK_W-1:0] pendBank_q  [NUM_PORT];
  logic [BANK_W-1:0] pendBank_d  [NUM_PORT];

  function automatic logic [PORT_W-1:0] nextPort(input logic [PORT_W-1:0] p);
    return (p == PORT_W'(NUM_PORT - 1)) ? '0 : p + PORT_W'(1);
  endfunction

  // No grants while reset is held, so bank strobes and req_rdy stay low.
  always_comb begin
    candPort = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      grant[b]  = 1'b0;
      winner[b] = '0;
      if (reset) begin
        if (state_q[b] == LOCKED) begin
          if (bus.req_vld[owner_q[b]] && bus.req_bank[owner_q[b]] == BANK_W'(b)) begin
            grant[b]  = 1'b1;
            winner[b] = owner_q[b];
          end
        end else begin
          for (int i = 0; i < NUM_PORT; i++) begin
            candPort = PORT_W'((int'(rrPtr_q[b]) + i) % NUM_PORT);
            if (!grant[b] && bus.req_vld[candPort] && bus.req_bank[candPort] == BANK_W'(b)) begin
              grant[b]  = 1'b1;
              winner[b] = candPort;
            end
          end
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORT; p++) begin
      portRdy[p] = 1'b0;
    end
    for (int b = 0; b < NUM_BANK; b++) begin
      if (grant[b]) begin
        portRdy[winner[b]] = 1'b1;
      end
      bus.bank_en[b]    = grant[b];
      bus.bank_we[b]    = grant[b] & bus.req_we[winner[b]];
      bus.bank_addr[b]  = grant[b] ? bus.req_addr[winner[b]] : '0;
      bus.bank_wdata[b] = grant[b] ? bus.req_wdata[winner[b]] : '0;
    end
    for (int p = 0; p < NUM_PORT; p++) begin
      bus.req_rdy[p]   = portRdy[p];
      pendVld_d[p]     = portRdy[p];
      pendWe_d[p]      = portRdy[p] & bus.req_we[p];
      pendBank_d[p]    = portRdy[p] ? bus.req_bank[p] : '0;
      bus.rsp_vld[p]   = pendVld_q[p];
      bus.rsp_we[p]    = pendWe_q[p];
      bus.rsp_bank[p]  = pendBank_q[p];
      bus.rsp_rdata[p] = (pendVld_q[p] && !pendWe_q[p]) ? bus.bank_rdata[pendBank_q[p]] : '0;
    end
  end

  // len is only sampled on the first beat; 0 and 1 both mean a single-beat grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < NUM_BANK; b++) begin
        state_q[b]     <= IDLE;
        owner_q[b]     <= '0;
        remaining_q[b] <= '0;
        rrPtr_q[b]     <= '0;
      end
      for (int p = 0; p < NUM_PORT; p++) begin
        pendVld_q[p]  <= 1'b0;
        pendWe_q[p]   <= 1'b0;
        pendBank_q[p] <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BANK; b++) begin
        if (grant[b]) begin
          if (state_q[b] == IDLE) begin
            if (bus.req_len[winner[b]] > LEN_W'(1)) begin
              state_q[b]     <= LOCKED;
              owner_q[b]     <= winner[b];
              remaining_q[b] <= bus.req_len[winner[b]] - LEN_W'(1);
            end else begin
              rrPtr_q[b] <= nextPort(winner[b]);
            end
          end else if (remaining_q[b] == LEN_W'(1)) begin
            state_q[b]     <= IDLE;
            remaining_q[b] <= '0;
            rrPtr_q[b]     <= nextPort(owner_q[b]);
          end else begin
            remaining_q[b] <= remaining_q[b] - LEN_W'(1);
          end
        end
      end
      for (int p = 0; p < NUM_PORT; p++) begin
        pendVld_q[p]  <= pendVld_d[p];
        pendWe_q[p]   <= pendWe_d[p];
        pendBank_q[p] <= pendBank_d[p];
      end
    end
  end
endmodule
